// File: rtl/prog_load_harness_if.sv
// Load-stream interface between the host/bench word source and the harness.
//   ld_valid : stream word valid (host -> harness)
//   ld_ready : harness can accept a word (harness -> host)
//   ld_data  : stream word
//   ld_sel   : 0 = instruction memory, 1 = data memory
//   ld_last  : final word of the load
interface prog_load_harness_if #(
  parameter int SIZE = 32
) ();
  logic            ld_valid;
  logic            ld_ready;
  logic [SIZE-1:0] ld_data;
  logic            ld_sel;
  logic            ld_last;

  modport master (
    output ld_valid, ld_data, ld_sel, ld_last,
    input  ld_ready
  );

  modport slave (
    input  ld_valid, ld_data, ld_sel, ld_last,
    output ld_ready
  );
endinterface

// File: rtl/prog_load_harness.sv
// Load/run controller for the single-cycle core test environment.
// Streams a program into instruction memory and optional init data into data
// memory while holding the core in reset, then releases the core, counts run
// cycles and ends the run on a store to TOHOST_ADDR or on a cycle-limit timeout.
// Ports:
//   CLK, RESET_N          : clock, synchronous active-low reset
//   start                 : begin a load (honoured in IDLE/DONE only)
//   ld (slave)            : load word stream with valid/ready handshake
//   imem_we/addr/wdata    : instruction memory write port (registered)
//   dmem_we/addr/wdata    : data memory init write port (registered)
//   core_reset_n          : active-low reset to the core, high only in RUN
//   core_dwe/daddr/dwdata : snooped core data-store bus
//   done, pass, timeout   : run completion status
//   overflow              : a load word exceeded its memory depth (sticky)
//   result                : value stored to TOHOST
//   cycle_count           : number of RUN cycles
module prog_load_harness #(
  parameter int                    ADDR_WIDTH  = 10,
  parameter int                    SIZE        = 32,
  parameter int                    IMEM_DEPTH  = 1024,
  parameter int                    DMEM_DEPTH  = 1024,
  parameter int                    MAX_CYCLES  = 1000,
  parameter int                    CNT_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR = 10'h3FF,
  parameter logic [SIZE-1:0]       PASS_VALUE  = 32'd1
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  start,
  prog_load_harness_if.slave    ld,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [SIZE-1:0]       imem_wdata,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [SIZE-1:0]       dmem_wdata,
  output logic                  core_reset_n,
  input  logic                  core_dwe,
  input  logic [ADDR_WIDTH-1:0] core_daddr,
  input  logic [SIZE-1:0]       core_dwdata,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic                  overflow,
  output logic [SIZE-1:0]       result,
  output logic [CNT_WIDTH-1:0]  cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_RUN,
    S_DONE
  } state_t;

  // Counters carry one extra bit so they can sit at DEPTH == 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0]  IMEM_LIM  = (ADDR_WIDTH+1)'(IMEM_DEPTH);
  localparam logic [ADDR_WIDTH:0]  DMEM_LIM  = (ADDR_WIDTH+1)'(DMEM_DEPTH);
  localparam logic [CNT_WIDTH-1:0] LAST_CYC  = CNT_WIDTH'(MAX_CYCLES - 1);

  state_t                state, state_nx;
  logic [ADDR_WIDTH:0]   imem_cnt, dmem_cnt;
  logic                  hs, halt, hit_limit, load_entry;

  assign hs         = ld.ld_valid & ld.ld_ready;
  assign halt       = core_dwe && (core_daddr == TOHOST_ADDR);
  assign hit_limit  = (cycle_count == LAST_CYC);
  assign load_entry = (state == S_IDLE || state == S_DONE) && start;

  always_ff @(posedge CLK) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE,
      S_DONE:  if (start) state_nx = S_LOAD;
      S_LOAD:  if (hs && ld.ld_last) state_nx = S_DRAIN;
      S_DRAIN: state_nx = S_RUN;
      S_RUN:   if (halt || hit_limit) state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Decoded straight from the state register, so these behave as registered outputs.
  always_comb begin
    ld.ld_ready  = (state == S_LOAD);
    core_reset_n = (state == S_RUN);
    done         = (state == S_DONE);
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      imem_cnt    <= '0;
      dmem_cnt    <= '0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      overflow    <= 1'b0;
      result      <= '0;
      cycle_count <= '0;
    end else begin
      imem_we <= 1'b0;
      dmem_we <= 1'b0;

      if (load_entry) begin
        imem_cnt    <= '0;
        dmem_cnt    <= '0;
        pass        <= 1'b0;
        timeout     <= 1'b0;
        overflow    <= 1'b0;
        result      <= '0;
        cycle_count <= '0;
      end

      // Words past a target's depth are still accepted but dropped.
      if (state == S_LOAD && hs) begin
        if (!ld.ld_sel) begin
          if (imem_cnt == IMEM_LIM) begin
            overflow <= 1'b1;
          end else begin
            imem_we    <= 1'b1;
            imem_addr  <= imem_cnt[ADDR_WIDTH-1:0];
            imem_wdata <= ld.ld_data;
            imem_cnt   <= imem_cnt + 1'b1;
          end
        end else begin
          if (dmem_cnt == DMEM_LIM) begin
            overflow <= 1'b1;
          end else begin
            dmem_we    <= 1'b1;
            dmem_addr  <= dmem_cnt[ADDR_WIDTH-1:0];
            dmem_wdata <= ld.ld_data;
            dmem_cnt   <= dmem_cnt + 1'b1;
          end
        end
      end

      if (state == S_RUN) begin
        cycle_count <= cycle_count + 1'b1;
        if (halt) begin
          result  <= core_dwdata;
          pass    <= (core_dwdata == PASS_VALUE);
          timeout <= 1'b0;
        end else if (hit_limit) begin
          result  <= '0;
          pass    <= 1'b0;
          timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_load_harness.sv
module tb_prog_load_harness;

  localparam int          AW     = 4;
  localparam int          SZ     = 32;
  localparam int          IDEPTH = 4;
  localparam int          DDEPTH = 3;
  localparam int          MAXC   = 16;
  localparam int          CW     = 16;
  localparam logic [3:0]  TOHOST = 4'hF;
  localparam logic [31:0] PASSV  = 32'd1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          imem_we, dmem_we, core_reset_n;
  logic [AW-1:0] imem_addr, dmem_addr;
  logic [SZ-1:0] imem_wdata, dmem_wdata;
  logic          core_dwe = 1'b0;
  logic [AW-1:0] core_daddr = '0;
  logic [SZ-1:0] core_dwdata = '0;
  logic          done, pass, timeout, overflow;
  logic [SZ-1:0] result;
  logic [CW-1:0] cycle_count;

  prog_load_harness_if #(.SIZE(SZ)) ld_if ();

  prog_load_harness #(
    .ADDR_WIDTH (AW),
    .SIZE       (SZ),
    .IMEM_DEPTH (IDEPTH),
    .DMEM_DEPTH (DDEPTH),
    .MAX_CYCLES (MAXC),
    .CNT_WIDTH  (CW),
    .TOHOST_ADDR(TOHOST),
    .PASS_VALUE (PASSV)
  ) dut (
    .CLK         (clk),
    .RESET_N     (rst_n),
    .start       (start),
    .ld          (ld_if.slave),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .core_reset_n(core_reset_n),
    .core_dwe    (core_dwe),
    .core_daddr  (core_daddr),
    .core_dwdata (core_dwdata),
    .done        (done),
    .pass        (pass),
    .timeout     (timeout),
    .overflow    (overflow),
    .result      (result),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [SZ-1:0] d;
  } wr_t;

  typedef struct {
    logic [31:0] res;
    bit          pas;
    bit          to;
    bit          ovf;
    int          cnt;
  } run_t;

  wr_t  iq[$];
  wr_t  dq[$];
  run_t rq[$];

  int   checks = 0;
  int   errors = 0;

  // Reference model of the load: per-target word counts and sticky overflow.
  int   m_icnt = 0;
  int   m_dcnt = 0;
  bit   m_ovf  = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Scoreboard monitor: pops an expectation whenever the DUT presents a write or completes a run.
  logic done_q = 1'b0;
  always @(negedge clk) begin
    wr_t  w;
    run_t r;
    if (imem_we === 1'b1) begin
      if (iq.size() == 0) begin
        chk("imem_unexpected_write", {imem_addr, imem_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        w = iq.pop_front();
        chk("imem_addr", imem_addr, w.a);
        chk("imem_wdata", imem_wdata, w.d);
      end
    end
    if (dmem_we === 1'b1) begin
      if (dq.size() == 0) begin
        chk("dmem_unexpected_write", {dmem_addr, dmem_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        w = dq.pop_front();
        chk("dmem_addr", dmem_addr, w.a);
        chk("dmem_wdata", dmem_wdata, w.d);
      end
    end
    if (done === 1'b1 && done_q === 1'b0) begin
      if (rq.size() == 0) begin
        chk("done_unexpected", done, 0);
      end else begin
        r = rq.pop_front();
        chk("result", result, r.res);
        chk("pass", pass, r.pas);
        chk("timeout", timeout, r.to);
        chk("overflow", overflow, r.ovf);
        chk("cycle_count", cycle_count, r.cnt);
        chk("core_reset_n_done", core_reset_n, 0);
        chk("ld_ready_done", ld_if.ld_ready, 0);
      end
    end
    done_q = done;
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_imem_we"}, imem_we, 0);
    chk({tag, "_imem_addr"}, imem_addr, 0);
    chk({tag, "_imem_wdata"}, imem_wdata, 0);
    chk({tag, "_dmem_we"}, dmem_we, 0);
    chk({tag, "_dmem_addr"}, dmem_addr, 0);
    chk({tag, "_dmem_wdata"}, dmem_wdata, 0);
    chk({tag, "_core_reset_n"}, core_reset_n, 0);
    chk({tag, "_ld_ready"}, ld_if.ld_ready, 0);
    chk({tag, "_status"}, {done, pass, timeout, overflow}, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_cycle_count"}, cycle_count, 0);
  endtask

  task automatic begin_load();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    m_icnt = 0;
    m_dcnt = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic send_word(input bit sel, input logic [31:0] data, input bit last, input int gap);
    int  tries;
    bit  rdy;
    wr_t w;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    ld_if.ld_valid = 1'b1;
    ld_if.ld_sel   = sel;
    ld_if.ld_data  = data;
    ld_if.ld_last  = last;
    tries = 0;
    rdy   = 1'b0;
    while (!rdy && tries < 8) begin
      @(negedge clk);
      rdy = (ld_if.ld_ready === 1'b1);
      tries++;
    end
    if (!rdy) begin
      chk("ld_ready_wait", ld_if.ld_ready, 1);
      ld_if.ld_valid = 1'b0;
      return;
    end
    @(posedge clk);
    w.d = data;
    if (!sel) begin
      if (m_icnt < IDEPTH) begin
        w.a = AW'(m_icnt);
        iq.push_back(w);
        m_icnt++;
      end else m_ovf = 1'b1;
    end else begin
      if (m_dcnt < DDEPTH) begin
        w.a = AW'(m_dcnt);
        dq.push_back(w);
        m_dcnt++;
      end else m_ovf = 1'b1;
    end
    #1;
    ld_if.ld_valid = 1'b0;
    ld_if.ld_last  = 1'b0;
  endtask

  // Called #1 after the edge that took the last word. halt_cyc outside 1..MAXC means no halt.
  task automatic run_core(input int halt_cyc, input logic [31:0] val, input bit noise);
    run_t r;
    int   end_cyc;
    int   tries;
    bit   halts;
    halts = (halt_cyc >= 1 && halt_cyc <= MAXC);
    if (halts) begin
      r.res = val; r.pas = (val == PASSV); r.to = 1'b0; r.cnt = halt_cyc;
    end else begin
      r.res = '0;  r.pas = 1'b0;           r.to = 1'b1; r.cnt = MAXC;
    end
    r.ovf = m_ovf;
    rq.push_back(r);
    end_cyc = halts ? halt_cyc : MAXC;
    chk("core_reset_n_drain", core_reset_n, 0);
    for (int k = 1; k <= end_cyc; k++) begin
      @(posedge clk); #1;
      if (k == 1) chk("core_reset_n_run", core_reset_n, 1);
      if (k == halt_cyc) begin
        core_dwe    = 1'b1;
        core_daddr  = TOHOST;
        core_dwdata = val;
      end else if (noise) begin
        core_dwe    = 1'b1;
        core_daddr  = (k % 2 == 1) ? AW'(5) : AW'($urandom_range(0, 14));
        core_dwdata = $urandom;
        ld_if.ld_valid = $urandom_range(0, 1) == 1;
      end else begin
        core_dwe    = 1'b0;
        core_daddr  = AW'($urandom_range(0, 15));
        core_dwdata = PASSV;
      end
    end
    @(posedge clk); #1;
    core_dwe       = 1'b0;
    ld_if.ld_valid = 1'b0;
    tries = 0;
    while (done !== 1'b1 && tries < 4) begin
      @(negedge clk);
      tries++;
    end
    if (done !== 1'b1) chk("done_wait", done, 1);
    @(negedge clk);
  endtask

  task automatic reset_mid_run(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_all_zero("reset_mid_run");
    rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prog [4];
    bit          ov_sel [8];
    int          n;
    prog[0] = 32'h13; prog[1] = 32'h93; prog[2] = 32'h113; prog[3] = 32'h193;
    ov_sel[0] = 0; ov_sel[1] = 0; ov_sel[2] = 1; ov_sel[3] = 0;
    ov_sel[4] = 0; ov_sel[5] = 1; ov_sel[6] = 0; ov_sel[7] = 0;

    ld_if.ld_valid = 1'b0;
    ld_if.ld_sel   = 1'b0;
    ld_if.ld_data  = '0;
    ld_if.ld_last  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("por");
    rst_n = 1'b1;

    // Program load then halt with pass in RUN cycle 7.
    begin_load();
    for (int i = 0; i < 4; i++) send_word(1'b0, prog[i], i == 3, 0);
    run_core(7, PASSV, 1'b0);

    // Failing TOHOST value with stray stores elsewhere.
    begin_load();
    send_word(1'b0, 32'h6F, 1'b1, 0);
    run_core(5, 32'hDEAD, 1'b1);

    // Timeout with only non-TOHOST stores.
    begin_load();
    send_word(1'b0, 32'h13, 1'b0, 0);
    send_word(1'b1, 32'h55, 1'b1, 1);
    run_core(0, 0, 1'b1);

    // Halt in the final allowed cycle beats the timeout.
    begin_load();
    send_word(1'b0, 32'h13, 1'b1, 0);
    run_core(MAXC, PASSV, 1'b0);

    // Overflow with interleaved targets.
    begin_load();
    for (int i = 0; i < 8; i++) send_word(ov_sel[i], 32'h100 + 32'(i), i == 7, 0);
    run_core(3, PASSV, 1'b0);

    // Reset mid-RUN, then reload with a stray start during LOAD.
    begin_load();
    send_word(1'b0, 32'hAA, 1'b0, 0);
    send_word(1'b1, 32'hBB, 1'b1, 0);
    reset_mid_run(3);
    begin_load();
    send_word(1'b0, 32'h11, 1'b0, 0);
    send_word(1'b1, 32'h22, 1'b0, 0);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send_word(1'b0, 32'h33, 1'b0, 0);
    send_word(1'b1, 32'h44, 1'b1, 0);
    run_core(4, 32'h2, 1'b0);

    // Randomized loads and runs.
    for (int t = 0; t < 14; t++) begin
      int          hc;
      logic [31:0] v;
      begin_load();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++)
        send_word($urandom_range(0, 1) == 1, $urandom, i == n - 1, $urandom_range(0, 2));
      hc = $urandom_range(1, 20);
      v  = ($urandom_range(0, 1) == 1) ? PASSV : $urandom;
      run_core(hc, v, $urandom_range(0, 1) == 1);
    end

    repeat (3) @(negedge clk);
    chk("imem_queue_empty", iq.size(), 0);
    chk("dmem_queue_empty", dq.size(), 0);
    chk("run_queue_empty", rq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_load_harness.md
Name: prog_load_harness

Overview:
- Synthesisable load/run controller for the single-cycle core's test environment.
- Streams a program into instruction memory and optional init data into data memory, holding the core in reset meanwhile.
- Then releases the core, counts cycles, and detects completion via a store to a TOHOST address or a cycle-limit timeout.
- Sits between a host/bench word stream and the core's memories and reset. Replaces hard-wired ROM file loading and fixed-length runs.

Parameters:
ADDR_WIDTH, 10, word-address width of both memory write ports and of core_daddr
SIZE, 32, data word width
IMEM_DEPTH, 1024, instruction words writable (at most 2**ADDR_WIDTH)
DMEM_DEPTH, 1024, data words writable (at most 2**ADDR_WIDTH)
MAX_CYCLES, 1000, run-cycle limit before timeout (at least 2)
CNT_WIDTH, 32, cycle counter width
TOHOST_ADDR, 10'h3FF, data word address whose store ends the run
PASS_VALUE, 32'd1, TOHOST store value meaning pass

Ports:
CLK  in  1  clock, all state updates on rising edge
RESET_N  in  1  synchronous active-low reset
start  in  1  single-cycle pulse: begin a load (honoured only in IDLE/DONE)
ld_valid  in  1  stream word valid
ld_ready  out  1  stream ready
ld_data  in  SIZE  stream word
ld_sel  in  1  0 = instruction memory, 1 = data memory
ld_last  in  1  final word of the load
imem_we  out  1  instruction memory write strobe
imem_addr  out  ADDR_WIDTH  instruction write address
imem_wdata  out  SIZE  instruction write data
dmem_we  out  1  data memory init write strobe
dmem_addr  out  ADDR_WIDTH  data init write address
dmem_wdata  out  SIZE  data init write data
core_reset_n  out  1  reset to core, active-low
core_dwe  in  1  core data write enable (snooped)
core_daddr  in  ADDR_WIDTH  core data address (snooped)
core_dwdata  in  SIZE  core write data (snooped)
done  out  1  run finished
pass  out  1  finished with PASS_VALUE
timeout  out  1  finished by cycle limit
overflow  out  1  a load word exceeded its memory depth
result  out  SIZE  value stored to TOHOST
cycle_count  out  CNT_WIDTH  core run cycles

Behaviour:
- Reset: RESET_N=0 at an edge puts the FSM in IDLE.
  - All outputs 0, including core_reset_n=0 and ld_ready=0.
  - Both address counters 0.
  - Applies from any state, including mid-LOAD or mid-RUN.
- States: IDLE, LOAD, DRAIN, RUN, DONE.
- IDLE: ld_ready=0. start moves to LOAD.
- DONE: ld_ready=0. start moves to LOAD.
- Entering LOAD clears the address counters, done, pass, timeout, overflow, result and cycle_count.
- LOAD: ld_ready=1. Handshake = ld_valid & ld_ready.
  - Write outputs are registered: the write is driven in the cycle after the handshake, we high for exactly one cycle.
  - Address = the selected target's counter; that counter then increments by 1.
  - Counters are independent per target; words for the two targets may interleave.
  - A handshake with counter == DEPTH of its target: the word is accepted, no write occurs, overflow is set sticky, and the counter does not move.
  - A handshake with ld_last=1 moves to DRAIN; ld_ready=0 from the next cycle.
- DRAIN: one cycle; the final write strobe is driven here. Next state RUN.
- RUN: core_reset_n=1, registered, so it is first high in the cycle after DRAIN.
  - cycle_count increments by 1 every RUN cycle, including the terminating cycle.
  - Halt: core_dwe=1 and core_daddr==TOHOST_ADDR. Next edge goes to DONE with result=core_dwdata, pass=(core_dwdata==PASS_VALUE), timeout=0.
  - Timeout: no halt and cycle_count==MAX_CYCLES-1. Next edge goes to DONE with timeout=1, pass=0, result=0.
  - Halt and timeout in the same cycle: halt wins.
  - Stores to other addresses are ignored.
- DONE: done=1, core_reset_n=0. result, pass, timeout, overflow and cycle_count hold until the next start or reset.
- start outside IDLE/DONE is ignored. ld_valid outside LOAD is ignored.
- cycle_count wraps modulo 2**CNT_WIDTH; MAX_CYCLES must be at most 2**CNT_WIDTH.

Test Plan:
- Load: start, then 4 imem words 0x13,0x93,0x113,0x193 back-to-back with ld_last on the 4th -> imem_we pulses at addr 0..3 with matching data, core_reset_n first high 2 cycles after the last handshake.
- Halt: after the load, the core stores 1 to TOHOST_ADDR in RUN cycle 7 -> done=1, pass=1, result=1, cycle_count=7, core_reset_n=0 the next cycle.
- Fail: store 0xDEAD to TOHOST_ADDR -> pass=0, result=0xDEAD, timeout=0. A store to address 5 alone -> no effect.
- Timeout: MAX_CYCLES=16, no TOHOST store -> done after 16 RUN cycles, timeout=1, cycle_count=16. With a halt in cycle 16 -> pass decided by the halt value, timeout=0.
- Overflow/interleave: IMEM_DEPTH=4, 6 imem words mixed with 2 dmem words -> imem writes at addr 0..3 only, dmem writes at addr 0..1, overflow=1.
- Reset mid-RUN and restart: RESET_N=0 in RUN -> all outputs 0 after the edge. Then start and reload -> normal operation. start pulsed during LOAD -> ignored, counters not cleared.
